fft_frame_ctrl: RTL and testbench

- Frames the audio sample stream for the FFT core: collects FRAME_LEN samples into a ping-pong buffer, then streams each full frame to the FFT input with valid/ready/sop/eop.
- Generates the FFT core reset (fft_rst_n) after system reset.
- Sits between the audio capture path and the FFT core, in the clk_50m domain. Audio samples arrive already synchronised as single-cycle strobes.

---
 rtl/fft_frame_ctrl_if.sv | 27 ++
 rtl/fft_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_ctrl_if.sv
// FFT input stream bundle: valid/ready beats with sop/eop framing.
// master drives valid/sop/eop/data, slave (FFT core) drives ready.
interface fft_frame_ctrl_if #(
   parameter int OUT_W = 16
) ();
   logic               fft_valid;
   logic               fft_ready;
   logic               fft_sop;
   logic               fft_eop;
   logic [2*OUT_W-1:0] fft_data;

   modport master (
      output fft_valid,
      output fft_sop,
      output fft_eop,
      output fft_data,
      input  fft_ready
   );

   modport slave (
      input  fft_valid,
      input  fft_sop,
      input  fft_eop,
      input  fft_data,
      output fft_ready
   );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frames audio samples into ping-pong banks and streams full frames to the FFT.
// Ports: clk_50m/rst_n, audio_valid/audio_data in, fft (master stream),
// fft_rst_n core reset, sticky overflow, frame_cnt completed frames.
module fft_frame_ctrl #(
   parameter int FRAME_LEN  = 256,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 24,
   parameter int OUT_W      = 16,
   parameter int RST_CYCLES = 16
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              audio_valid,
   input  logic [DATA_W-1:0] audio_data,
   fft_frame_ctrl_if.master  fft,
   output logic              fft_rst_n,
   output logic              overflow,
   output logic [15:0]       frame_cnt
);
   localparam int RC_W = $clog2(RST_CYCLES + 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {S_RST, S_IDLE, S_SEND} state_t;

   state_t            state;
   logic [1:0]        bank_full;
   logic [1:0]        bank_full_nxt;
   logic              wr_bank;
   logic              rd_bank;
   logic [ADDR_W-1:0] wr_idx;
   logic [ADDR_W-1:0] rd_idx;
   logic [ADDR_W-1:0] rd_nxt;
   logic [RC_W-1:0]   rst_cnt;
   logic [OUT_W-1:0]  mem [2][FRAME_LEN];
   logic [OUT_W-1:0]  sample;
   logic [OUT_W-1:0]  rd_word;
   logic              xfer;
   logic              last_xfer;
   logic              accept;
   logic              drop;
   logic              unused_lsb;

   assign sample     = audio_data[DATA_W-1 -: OUT_W];
   assign unused_lsb = ^audio_data[DATA_W-OUT_W-1:0];

   assign xfer      = fft.fft_valid && fft.fft_ready;
   assign last_xfer = xfer && fft.fft_eop;

   // A bank freed by the eop transfer can take a sample at the same edge.
   assign accept = audio_valid &&
                   (!bank_full[wr_bank] ||
                    (last_xfer && (wr_bank == rd_bank)));
   assign drop   = audio_valid && !accept;

   // Read address of the beat to present after this edge.
   assign rd_nxt  = (state == S_IDLE) ? '0 : rd_idx + ADDR_W'(1);
   assign rd_word = mem[rd_bank][rd_nxt];

   always_comb begin
      bank_full_nxt = bank_full;
      if (last_xfer)
         bank_full_nxt[rd_bank] = 1'b0;
      if (accept && (wr_idx == LAST))
         bank_full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk_50m) begin
      if (rst_n && accept)
         mem[wr_bank][wr_idx] <= sample;
   end

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         state         <= S_RST;
         rst_cnt       <= '0;
         fft_rst_n     <= 1'b0;
         fft.fft_valid <= 1'b0;
         fft.fft_sop   <= 1'b0;
         fft.fft_eop   <= 1'b0;
         fft.fft_data  <= '0;
         overflow      <= 1'b0;
         frame_cnt     <= '0;
         bank_full     <= '0;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         wr_idx        <= '0;
         rd_idx        <= '0;
      end else begin
         bank_full <= bank_full_nxt;

         if (accept) begin
            if (wr_idx == LAST) begin
               wr_idx  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_idx <= wr_idx + ADDR_W'(1);
            end
         end

         if (drop)
            overflow <= 1'b1;

         unique case (state)
            S_RST: begin
               if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                  fft_rst_n <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  rst_cnt <= rst_cnt + RC_W'(1);
               end
            end
            S_IDLE: begin
               if (bank_full[rd_bank]) begin
                  state         <= S_SEND;
                  rd_idx        <= '0;
                  fft.fft_valid <= 1'b1;
                  fft.fft_sop   <= 1'b1;
                  fft.fft_eop   <= 1'b0;
                  fft.fft_data  <= {{OUT_W{1'b0}}, rd_word};
               end
            end
            S_SEND: begin
               if (xfer) begin
                  if (fft.fft_eop) begin
                     state         <= S_IDLE;
                     fft.fft_valid <= 1'b0;
                     fft.fft_sop   <= 1'b0;
                     fft.fft_eop   <= 1'b0;
                     fft.fft_data  <= '0;
                     rd_bank       <= ~rd_bank;
                     frame_cnt     <= frame_cnt + 16'd1;
                  end else begin
                     rd_idx       <= rd_nxt;
                     fft.fft_sop  <= 1'b0;
                     fft.fft_eop  <= (rd_nxt == LAST);
                     fft.fft_data <= {{OUT_W{1'b0}}, rd_word};
                  end
               end
            end
            default: state <= S_RST;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: reset, framing, backpressure,
// overflow, ping-pong streaming and mid-frame reset.
module tb_fft_frame_ctrl;
   localparam int FL = 256;

   logic        clk_50m = 1'b0;
   logic        rst_n;
   logic        audio_valid;
   logic [23:0] audio_data;
   logic        fft_rst_n;
   logic        overflow;
   logic [15:0] frame_cnt;

   fft_frame_ctrl_if #(.OUT_W(16)) bus ();

   fft_frame_ctrl #(
      .FRAME_LEN(256), .ADDR_W(8), .DATA_W(24),
      .OUT_W(16), .RST_CYCLES(16)
   ) dut (
      .clk_50m(clk_50m),
      .rst_n(rst_n),
      .audio_valid(audio_valid),
      .audio_data(audio_data),
      .fft(bus),
      .fft_rst_n(fft_rst_n),
      .overflow(overflow),
      .frame_cnt(frame_cnt)
   );

   always #10 clk_50m = ~clk_50m;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] beat_q[$];
   logic [1:0]  flag_q[$];
   int          gap_q[$];
   logic        prev_valid = 1'b0;
   logic        prev_last = 1'b0;
   logic        stalled = 1'b0;
   logic [33:0] held = '0;
   int          hold_bad = 0;
   int          imag_bad = 0;
   int          drop_bad = 0;
   int          last_eop_cyc = -1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      beat_q.delete();
      flag_q.delete();
      gap_q.delete();
      hold_bad     = 0;
      imag_bad     = 0;
      drop_bad     = 0;
      last_eop_cyc = -1;
   endtask

   // Observe the current cycle, then advance one clock.
   task automatic tick();
      logic xf;
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_last  = 1'b0;
         stalled    = 1'b0;
      end else begin
         if (stalled && bus.fft_valid &&
             {bus.fft_data, bus.fft_sop, bus.fft_eop} !== held)
            hold_bad++;
         if (prev_valid && !prev_last && !bus.fft_valid)
            drop_bad++;
         if (bus.fft_valid && !prev_valid && last_eop_cyc >= 0)
            gap_q.push_back(cyc - last_eop_cyc);
         xf = bus.fft_valid && bus.fft_ready;
         if (xf) begin
            beat_q.push_back(bus.fft_data[15:0]);
            flag_q.push_back({bus.fft_sop, bus.fft_eop});
            if (bus.fft_data[31:16] !== 16'h0)
               imag_bad++;
            if (bus.fft_eop)
               last_eop_cyc = cyc;
         end
         stalled    = bus.fft_valid && !bus.fft_ready;
         held       = {bus.fft_data, bus.fft_sop, bus.fft_eop};
         prev_valid = bus.fft_valid;
         prev_last  = xf && bus.fft_eop;
      end
      @(posedge clk_50m);
      #1;
      cyc++;
   endtask

   task automatic wait_beats(input string tag, input int n,
                             input int budget);
      int to;
      to = 1;
      for (int i = 0; i < budget; i++) begin
         if (beat_q.size() >= n && !bus.fft_valid) begin
            to = 0;
            break;
         end
         tick();
      end
      repeat (3) tick();
      chk({tag, "_done"}, 32'(to), 32'd0);
   endtask

   task automatic check_stream(input string tag, input int base,
                               input int n);
      int   m;
      int   bi;
      int   bf;
      logic s;
      logic e;
      chk({tag, "_count"}, 32'(beat_q.size()), 32'(n));
      m  = (beat_q.size() < n) ? beat_q.size() : n;
      bi = -1;
      bf = -1;
      for (int i = 0; i < m; i++) begin
         s = ((i % FL) == 0);
         e = ((i % FL) == FL - 1);
         if (beat_q[i] !== 16'(base + i) && bi < 0) bi = i;
         if (flag_q[i] !== {s, e} && bf < 0) bf = i;
      end
      if (m > 0) begin
         if (bi < 0) bi = m - 1;
         if (bf < 0) bf = m - 1;
         s = ((bf % FL) == 0);
         e = ((bf % FL) == FL - 1);
         chk({tag, "_data"}, 32'(beat_q[bi]), 32'(16'(base + bi)));
         chk({tag, "_sopeop"}, 32'(flag_q[bf]), 32'({s, e}));
      end
      chk({tag, "_imag"}, 32'(imag_bad), 32'd0);
      chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
      chk({tag, "_contig"}, 32'(drop_bad), 32'd0);
   endtask

   task automatic feed(input int base, input int n, input int gap);
      for (int k = 0; k < n; k++) begin
         audio_valid = 1'b1;
         audio_data  = 24'((base + k) << 8);
         tick();
         audio_valid = 1'b0;
         if (k < n - 1)
            repeat (gap) tick();
      end
   endtask

   initial begin
      int first_high;
      int bad;
      int to;
      int mg;

      rst_n         = 1'b0;
      audio_valid   = 1'b0;
      audio_data    = '0;
      bus.fft_ready = 1'b0;

      // Reset and fft_rst_n release timing
      repeat (3) tick();
      chk("rst_fft_rst_n", 32'(fft_rst_n), 32'd0);
      chk("rst_valid", 32'(bus.fft_valid), 32'd0);
      chk("rst_sopeop", 32'({bus.fft_sop, bus.fft_eop}), 32'd0);
      chk("rst_data", bus.fft_data, 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      rst_n      = 1'b1;
      first_high = -1;
      bad        = 0;
      for (int i = 0; i < 20; i++) begin
         if (fft_rst_n === 1'b1 && first_high < 0) first_high = i;
         if (first_high >= 0 && fft_rst_n !== 1'b1) bad++;
         if (bus.fft_valid | bus.fft_sop | bus.fft_eop | overflow)
            bad++;
         tick();
      end
      chk("t1_rst_len", 32'(first_high), 32'd16);
      chk("t1_quiet", 32'(bad), 32'd0);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'd0);

      // Single frame, one sample every 5 cycles
      clear_mon();
      bus.fft_ready = 1'b1;
      feed(0, FL, 4);
      chk("t2_lat_e", 32'(bus.fft_valid), 32'd0);
      tick();
      chk("t2_lat_e1", 32'({bus.fft_valid, bus.fft_sop}), 32'd3);
      wait_beats("t2", FL, 1000);
      check_stream("t2", 0, FL);
      chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);

      // Backpressure: stall cycles 10-19, then toggle ready
      clear_mon();
      bus.fft_ready = 1'b0;
      feed(0, FL, 4);
      to = 1;
      for (int i = 0; i < 10; i++) begin
         if (bus.fft_valid) begin
            to = 0;
            break;
         end
         tick();
      end
      chk("t3_start", 32'(to), 32'd0);
      for (int fc = 0; fc < 1000; fc++) begin
         if (beat_q.size() >= FL) break;
         bus.fft_ready = (fc < 10) ? 1'b1 :
                         (fc < 20) ? 1'b0 : 1'(fc % 2);
         tick();
      end
      bus.fft_ready = 1'b1;
      wait_beats("t3", FL, 50);
      check_stream("t3", 0, FL);
      chk("t3_frame_cnt", 32'(frame_cnt), 32'd2);

      // Overflow: both banks full, sample 512 dropped
      clear_mon();
      bus.fft_ready = 1'b0;
      for (int v = 0; v <= 512; v++) begin
         audio_valid = 1'b1;
         audio_data  = 24'(v << 8);
         tick();
         if (v == 511) chk("t4_ovf_before", 32'(overflow), 32'd0);
         if (v == 512) chk("t4_ovf_set", 32'(overflow), 32'd1);
      end
      audio_valid   = 1'b0;
      bus.fft_ready = 1'b1;
      wait_beats("t4", 2 * FL, 2000);
      check_stream("t4", 0, 2 * FL);
      chk("t4_gap_cnt", 32'(gap_q.size()), 32'd1);
      if (gap_q.size() > 0)
         chk("t4_gap", 32'(gap_q[0]), 32'd2);
      chk("t4_ovf_sticky", 32'(overflow), 32'd1);
      chk("t4_frame_cnt", 32'(frame_cnt), 32'd4);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst2_overflow", 32'(overflow), 32'd0);
      repeat (20) tick();

      // Ping-pong streaming, eight frames
      clear_mon();
      bus.fft_ready = 1'b1;
      feed(0, 8 * FL, 1);
      wait_beats("t5", 8 * FL, 2000);
      check_stream("t5", 0, 8 * FL);
      chk("t5_gap_cnt", 32'(gap_q.size()), 32'd7);
      mg = 1000000;
      foreach (gap_q[i])
         if (gap_q[i] < mg) mg = gap_q[i];
      chk("t5_gap_min_ok", 32'(mg >= 2), 32'd1);
      chk("t5_overflow", 32'(overflow), 32'd0);
      chk("t5_frame_cnt", 32'(frame_cnt), 32'd8);

      // Reset at beat 100 of a frame
      clear_mon();
      bus.fft_ready = 1'b1;
      feed(1000, FL, 0);
      to = 1;
      for (int i = 0; i < 400; i++) begin
         if (beat_q.size() >= 100) begin
            to = 0;
            break;
         end
         tick();
      end
      chk("t6_reach_100", 32'(to), 32'd0);
      rst_n = 1'b0;
      tick();
      chk("t6_fft_rst_n", 32'(fft_rst_n), 32'd0);
      chk("t6_valid", 32'(bus.fft_valid), 32'd0);
      chk("t6_sopeop", 32'({bus.fft_sop, bus.fft_eop}), 32'd0);
      chk("t6_data", bus.fft_data, 32'd0);
      chk("t6_overflow", 32'(overflow), 32'd0);
      chk("t6_frame_cnt0", 32'(frame_cnt), 32'd0);
      rst_n = 1'b1;
      clear_mon();
      feed(2000, FL, 0);
      wait_beats("t6", FL, 1000);
      check_stream("t6", 2000, FL);
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
